// File: rtl/counter_pkg.sv
// Shared constants and helpers for the BCD counter family.
// to_bcd is evaluated at elaboration to build per-instance limits.
package counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [31:0] to_bcd(
    input int v,
    input int ndig
  );
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig) begin
        r[i*4 +: 4] = 4'(x % 10);
        x           = x / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell: clear, load, increment or decrement
// with ripple carry/borrow to the next decade.
module bcd_digit
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             zero,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             carry,
  output logic             borrow
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (zero) begin
      digit <= '0;
    end else if (ld) begin
      digit <= ld_val;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end else if (dec) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign carry  = inc & (digit == BCD_MAX);
  assign borrow = dec & (digit == '0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with programmable modulus,
// wrap or saturate at the limits, and checked parallel load.
module bcd_mod_counter
  import counter_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter int MODULUS  = 60,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   load,
  input  logic [BCD_W*NDIGITS-1:0] load_val,
  input  logic                   en,
  input  logic                   up,
  output logic [BCD_W*NDIGITS-1:0] cnt,
  output logic                   tc,
  output logic                   wrapped,
  output logic                   load_err
);

  localparam int           W    = BCD_W * NDIGITS;
  localparam logic [W-1:0] MAXV = W'(to_bcd(MODULUS - 1, NDIGITS));
  localparam bit           SAT  = (SATURATE != 0);

  logic             at_max;
  logic             at_zero;
  logic             step_up;
  logic             step_dn;
  logic             wrap_up;
  logic             wrap_dn;
  logic             lv_ok;
  logic             zero_all;
  logic             ld_all;
  logic [W-1:0]     ld_bus;
  logic [NDIGITS:0] ci;
  logic [NDIGITS:0] bi;
  logic [NDIGITS-1:0] dig_ok;
  logic             unused_cout;

  assign at_max  = (cnt == MAXV);
  assign at_zero = (cnt == '0);
  assign step_up = en & up & ~clr & ~load;
  assign step_dn = en & ~up & ~clr & ~load;
  assign wrap_up = step_up & at_max;
  assign wrap_dn = step_dn & at_zero;
  assign tc      = wrap_up | wrap_dn;

  // Valid BCD digits compare numerically as plain binary.
  assign lv_ok = (&dig_ok) & (load_val <= MAXV);

  assign zero_all = clr | (wrap_up & ~SAT);
  assign ld_all   = (load & ~clr & lv_ok) | (wrap_dn & ~SAT);
  assign ld_bus   = load ? load_val : MAXV;

  assign ci[0] = step_up & ~at_max;
  assign bi[0] = step_dn & ~at_zero;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .reset  (reset),
      .zero   (zero_all),
      .ld     (ld_all),
      .ld_val (ld_bus[g*BCD_W +: BCD_W]),
      .inc    (ci[g]),
      .dec    (bi[g]),
      .digit  (cnt[g*BCD_W +: BCD_W]),
      .carry  (ci[g+1]),
      .borrow (bi[g+1])
    );
    assign dig_ok[g] = (load_val[g*BCD_W +: BCD_W] <= BCD_MAX);
  end

  // The limit compares stop the chain before it leaves the top digit.
  assign unused_cout = ci[NDIGITS] | bi[NDIGITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrapped  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrapped  <= ~SAT & (wrap_up | wrap_dn);
      load_err <= load & ~clr & ~lv_ok;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Randomised and directed bench for bcd_mod_counter against
// an integer reference model (three configs plus a 60x60 cascade).
module tb_bcd_mod_counter;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        load;
  logic        en;
  logic        up;
  logic [7:0]  lv8;
  logic [11:0] lv12;
  logic [7:0]  cnt0, cnt1;
  logic [11:0] cnt2;
  logic        tc0, tc1, tc2;
  logic        wr0, wr1, wr2;
  logic        le0, le1, le2;

  logic        c_one;
  logic        c_zero;
  logic [7:0]  c_lv;
  logic [7:0]  cs, cm;
  logic        tcs, tcm, wrs, wrm, les, lem;

  int nerr;
  int nchk;

  int mods [3] = '{60, 24, 1000};
  int sats [3] = '{0, 1, 0};
  int nds  [3] = '{2, 2, 3};
  int mv   [3];
  bit ew   [3];
  bit ee   [3];
  int ct;

  bcd_mod_counter #(.NDIGITS(2), .MODULUS(60), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv8),
    .en(en), .up(up), .cnt(cnt0), .tc(tc0), .wrapped(wr0), .load_err(le0)
  );

  bcd_mod_counter #(.NDIGITS(2), .MODULUS(24), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv8),
    .en(en), .up(up), .cnt(cnt1), .tc(tc1), .wrapped(wr1), .load_err(le1)
  );

  bcd_mod_counter #(.NDIGITS(3), .MODULUS(1000), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv12),
    .en(en), .up(up), .cnt(cnt2), .tc(tc2), .wrapped(wr2), .load_err(le2)
  );

  bcd_mod_counter #(.NDIGITS(2), .MODULUS(60), .SATURATE(0)) u_sec (
    .clk(clk), .reset(reset), .clr(c_zero), .load(c_zero), .load_val(c_lv),
    .en(c_one), .up(c_one), .cnt(cs), .tc(tcs), .wrapped(wrs), .load_err(les)
  );

  bcd_mod_counter #(.NDIGITS(2), .MODULUS(60), .SATURATE(0)) u_min (
    .clk(clk), .reset(reset), .clr(c_zero), .load(c_zero), .load_val(c_lv),
    .en(tcs), .up(c_one), .cnt(cm), .tc(tcm), .wrapped(wrm), .load_err(lem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tobcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  function automatic bit decode(input logic [31:0] lv, input int nd,
                                input int mod, output int val);
    int mult;
    int d;
    val  = 0;
    mult = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) return 1'b0;
      val  += d * mult;
      mult *= 10;
    end
    return val < mod;
  endfunction

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int i);
    case (i)
      0:       return {tc0, wr0, le0};
      1:       return {tc1, wr1, le1};
      default: return {tc2, wr2, le2};
    endcase
  endfunction

  task automatic model_edge();
    int          val;
    logic [31:0] lv;
    for (int i = 0; i < 3; i++) begin
      lv    = (i < 2) ? 32'(lv8) : 32'(lv12);
      ew[i] = 1'b0;
      ee[i] = 1'b0;
      if (clr) begin
        mv[i] = 0;
      end else if (load) begin
        if (decode(lv, nds[i], mods[i], val)) mv[i] = val;
        else ee[i] = 1'b1;
      end else if (en) begin
        if (up) begin
          if (mv[i] != mods[i] - 1) mv[i]++;
          else if (sats[i] == 0) begin mv[i] = 0; ew[i] = 1'b1; end
        end else begin
          if (mv[i] != 0) mv[i]--;
          else if (sats[i] == 0) begin mv[i] = mods[i] - 1; ew[i] = 1'b1; end
        end
      end
    end
  endtask

  task automatic tick();
    bit          etc;
    int          old;
    logic [31:0] mask;
    #1;
    for (int i = 0; i < 3; i++) begin
      etc = en & ~clr & ~load &
            ((up & (mv[i] == mods[i] - 1)) | (~up & (mv[i] == 0)));
      chk($sformatf("tc%0d", i), 32'(get_flags(i)[2]), 32'(etc));
    end
    chk("tc_min", 32'(tcm), 32'(ct == 3599));
    @(posedge clk);
    model_edge();
    old = ct;
    ct  = (ct + 1) % 3600;
    #1;
    for (int i = 0; i < 3; i++) begin
      mask = (i < 2) ? 32'h0000_00ff : 32'h0000_0fff;
      chk($sformatf("cnt%0d", i), get_cnt(i), tobcd(mv[i]) & mask);
      chk($sformatf("wrapped%0d", i), 32'(get_flags(i)[1]), 32'(ew[i]));
      chk($sformatf("load_err%0d", i), 32'(get_flags(i)[0]), 32'(ee[i]));
    end
    chk("casc_cnt", {16'h0, cm, cs},
        (tobcd(ct / 60) << 8) | (tobcd(ct % 60) & 32'hff));
    chk("casc_wrap", {30'h0, wrm, wrs},
        {30'h0, old == 3599, (old % 60) == 59});
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_cnt"}, get_cnt(i), 32'h0);
      chk({tag, "_pulse"}, 32'(get_flags(i)[1:0]), 32'h0);
    end
    chk({tag, "_casc"}, {16'h0, cm, cs}, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      ew[i] = 1'b0;
      ee[i] = 1'b0;
    end
    ct = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    nerr   = 0;
    nchk   = 0;
    c_one  = 1'b1;
    c_zero = 1'b0;
    c_lv   = 8'h00;
    reset  = 1'b0;
    clr    = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
    up     = 1'b1;
    lv8    = 8'h00;
    lv12   = 12'h000;
    model_reset();
    #12;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    en = 1'b1;
    up = 1'b1;
    run(61);

    up = 1'b0;
    run(12);

    up = 1'b1;
    run(30);
    up = 1'b0;
    run(30);

    en   = 1'b0;
    load = 1'b1;
    lv8  = 8'h45; lv12 = 12'h045; tick();
    lv8  = 8'h60; lv12 = 12'h3A0; tick();
    lv8  = 8'h3A; lv12 = 12'h0A5; tick();
    lv8  = 8'h23; lv12 = 12'h999; tick();
    clr  = 1'b1;
    lv8  = 8'h12; lv12 = 12'h123; tick();
    clr  = 1'b0;

    lv8 = 8'h09; lv12 = 12'h099; tick();
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1; tick();
    up   = 1'b0; tick();
    en   = 1'b0;
    load = 1'b1;
    lv8 = 8'h59; lv12 = 12'h999; tick();
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1; tick();

    clr = 1'b1; tick();
    clr = 1'b0;
    run(37);
    chk("pre_reset_cnt0", 32'(cnt0), 32'h37);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    #1;
    reset = 1'b1;

    for (int k = 0; k < 3700; k++) begin
      int r;
      r    = int'($urandom_range(0, 99));
      clr  = (r < 3);
      load = (r >= 3 && r < 14);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 1) == 0) begin
        lv8  = 8'(tobcd(int'($urandom_range(0, 99))));
        lv12 = 12'(tobcd(int'($urandom_range(0, 999))));
      end else begin
        lv8  = 8'($urandom);
        lv12 = 12'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
